spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- Single-lane SPI flash read master: SPI mode 0, standard READ command 0x03.
- Fetches 32-bit words from an external flash through the caravel flash pins (flash_csb, flash_clk, flash_io0, flash_io1).
- It is the initiator counterpart of the spiflash responder model; the bench pairs the two directly.
- Sequential word requests continue the open burst without reissuing the command or address.

Parameters:
CLK_DIV, 1, SCK half-period in clk cycles (legal 1..255); one SPI bit = 2*CLK_DIV clk cycles
CSB_IDLE, 2, minimum clk cycles flash_csb stays high between transactions (legal 1..15)

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset, sampled on rising clk
req_valid  input  1  word read request
req_ready  output  1  request accepted when req_valid && req_ready on a rising clk
req_addr  input  24  byte address; bits [1:0] ignored and treated as 0
rdata  output  32  read word, little-endian (first byte received -> [7:0])
rdata_valid  output  1  one-cycle pulse, rdata valid
busy  output  1  high in any state other than IDLE
flash_csb  output  1  flash chip select, active low
flash_clk  output  1  SCK
flash_io0  output  1  MOSI
flash_io1  input  1  MISO

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE, flash_csb=1, flash_clk=0, flash_io0=0, rdata=0, rdata_valid=0, busy=0, idle counter saturated so req_ready=1 on the first cycle after reset. Reset mid-transaction aborts it: csb goes high on that edge and no rdata_valid is issued.
- States:
  - IDLE: csb high, req_ready = (idle count >= CSB_IDLE). Accept -> latch addr, next_addr = addr+4 -> CMD.
  - CMD: shift out 8 bits of 0x03, MSB first -> ADDR.
  - ADDR: shift out 24 address bits, MSB first -> DATA.
  - DATA: shift in 32 bits, MSB of each byte first -> HOLD.
  - HOLD: csb low, sck low, req_ready=1.
    - Request with addr == next_addr -> DATA; next_addr += 4, wraps modulo 2^24.
    - Request with any other addr: not accepted. Drive csb high, go to IDLE, clear idle counter; that request is accepted once CSB_IDLE has elapsed.
    - No request: remain in HOLD indefinitely.
- Bit timing, D = CLK_DIV:
  - Each bit is a low phase of D cycles followed by a high phase of D cycles.
  - io0 is updated at the start of the low phase.
  - io1 is sampled on the clk edge where flash_clk rises.
  - During DATA, io0 is driven 0.
- Latency, accept edge T:
  - Fresh request: csb falls at T+1; bit k starts at T+1+2kD; flash_clk returns low and rdata_valid pulses at T+1+128D (D=1: T+129).
  - Sequential request from HOLD: rdata_valid at T+1+64D (D=1: T+65).
- rdata: updated only together with rdata_valid and held until the next pulse.
- req_ready: low in CMD, ADDR and DATA. No request is queued.
- HOLD edge cases:
  - Address wrap from 0xFFFFFC is sequential with 0x000000.
  - A request in the same cycle as the DATA->HOLD transition is accepted in the following cycle.

Test Plan:
- Preload spiflash hex 0x000000: 6F 00 40 0B; request addr 0x000000 with CLK_DIV=1 -> io0 shows 0x03 then 0x000000; rdata=0x0B40006F; rdata_valid exactly 129 cycles after accept; csb stays low afterwards.
- Follow with a request at 0x000004 (bytes 11 22 33 44) -> no command reissued; rdata=0x44332211 at accept+65.
- Then request 0x000100 -> csb high for >= CSB_IDLE=2 cycles, new 0x03 command with address 0x000100, correct word returned.
- Request addr 0x000007 -> treated as 0x000004.
- CLK_DIV=3 -> SCK period 6 cycles; rdata_valid at accept+385; data matches the CLK_DIV=1 run.
- Assert resetn=0 during ADDR phase -> csb=1, sck=0 on the next edge, no rdata_valid; a fresh request afterwards completes correctly.
- Request at 0xFFFFFC then 0x000000 -> second word served as sequential (no command reissued), spiflash returns byte 0 after wrap.

Source files
------------

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-lane SPI mode-0 flash read master issuing READ (0x03).
// Returns 32-bit little-endian words; sequential requests continue the open burst.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned CSB_IDLE = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 6;
    localparam int unsigned IDLE_W = 4;

    localparam logic [7:0]        CMD_READ  = 8'h03;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [IDLE_W-1:0] IDLE_MIN  = IDLE_W'(CSB_IDLE);
    localparam logic [ADDR_W-1:0] WORD_MASK = 24'hFFFFFC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_HOLD
    } state_t;

    state_t              state, state_n;
    logic                lead, lead_n;
    logic [DIV_W-1:0]    div_cnt, div_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic                sck, sck_n;
    logic                csb, csb_n;
    logic                io0, io0_n;
    logic [WORD_W-1:0]   sh_out, sh_out_n;
    logic [WORD_W-1:0]   sh_in, sh_in_n;
    logic [ADDR_W-1:0]   next_addr, next_addr_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_n;
    logic [WORD_W-1:0]   rdata_q, rdata_n;
    logic                valid_q, valid_n;
    logic                ready_q, ready_n;
    logic                busy_q, busy_n;
    logic [ADDR_W-1:0]   word_addr;

    assign word_addr = req_addr & WORD_MASK;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            lead      <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sck       <= 1'b0;
            csb       <= 1'b1;
            io0       <= 1'b0;
            sh_out    <= '0;
            sh_in     <= '0;
            next_addr <= '0;
            idle_cnt  <= IDLE_MIN;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            lead      <= lead_n;
            div_cnt   <= div_n;
            bit_cnt   <= bit_n;
            sck       <= sck_n;
            csb       <= csb_n;
            io0       <= io0_n;
            sh_out    <= sh_out_n;
            sh_in     <= sh_in_n;
            next_addr <= next_addr_n;
            idle_cnt  <= idle_n;
            rdata_q   <= rdata_n;
            valid_q   <= valid_n;
            ready_q   <= ready_n;
            busy_q    <= busy_n;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n     = state;
        lead_n      = lead;
        div_n       = div_cnt;
        bit_n       = bit_cnt;
        sck_n       = sck;
        csb_n       = csb;
        io0_n       = io0;
        sh_out_n    = sh_out;
        sh_in_n     = sh_in;
        next_addr_n = next_addr;
        idle_n      = idle_cnt;
        rdata_n     = rdata_q;
        valid_n     = 1'b0;

        case (state)
            S_IDLE: begin
                csb_n = 1'b1;
                sck_n = 1'b0;
                io0_n = 1'b0;
                if (idle_cnt < IDLE_MIN) begin
                    idle_n = idle_cnt + 4'd1;
                end
                if (req_valid && ready_q) begin
                    state_n     = S_CMD;
                    lead_n      = 1'b1;
                    bit_n       = '0;
                    sh_out_n    = {CMD_READ, word_addr};
                    next_addr_n = word_addr + 24'd4;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (lead) begin
                    // One setup cycle so the first SCK rise lands D cycles after csb/io0 settle
                    lead_n = 1'b0;
                    div_n  = '0;
                    csb_n  = 1'b0;
                    if (state != S_DATA) begin
                        io0_n    = sh_out[WORD_W-1];
                        sh_out_n = {sh_out[WORD_W-2:0], 1'b0};
                    end
                end else if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    sck_n = ~sck;
                    if (!sck) begin
                        if (state == S_DATA) begin
                            sh_in_n = {sh_in[WORD_W-2:0], flash_io1};
                        end
                    end else begin
                        bit_n = bit_cnt + 6'd1;
                        if (bit_cnt == 6'd63) begin
                            state_n = S_HOLD;
                            io0_n   = 1'b0;
                            valid_n = 1'b1;
                            rdata_n = {sh_in[7:0], sh_in[15:8], sh_in[23:16], sh_in[31:24]};
                        end else if (bit_cnt == 6'd31) begin
                            state_n = S_DATA;
                            io0_n   = 1'b0;
                        end else if (state != S_DATA) begin
                            if (bit_cnt == 6'd7) begin
                                state_n = S_ADDR;
                            end
                            io0_n    = sh_out[WORD_W-1];
                            sh_out_n = {sh_out[WORD_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                csb_n = 1'b0;
                sck_n = 1'b0;
                io0_n = 1'b0;
                if (req_valid) begin
                    if (word_addr == next_addr) begin
                        state_n     = S_DATA;
                        lead_n      = 1'b1;
                        bit_n       = 6'd32;
                        next_addr_n = next_addr + 24'd4;
                    end else begin
                        // Non-sequential: close the burst; the request is taken later from IDLE
                        state_n = S_IDLE;
                        csb_n   = 1'b1;
                        idle_n  = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                csb_n   = 1'b1;
            end
        endcase

        ready_n = (state_n == S_HOLD) || ((state_n == S_IDLE) && (idle_n >= IDLE_MIN));
        busy_n  = (state_n != S_IDLE);
    end

    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign rdata_valid = valid_q;
    assign flash_csb   = csb;
    assign flash_clk   = sck;
    assign flash_io0   = io0;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench: two readers (CLK_DIV=1 and 3) fed identical request streams, each paired
// with a behavioural SPI flash responder; a scoreboard checks data, latency and commands.
module tb_spi_flash_reader;
    localparam int unsigned CSB_MIN = 2;
    localparam int unsigned NRND    = 16;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
        int          cmds;
        logic [23:0] cmd_addr;
    } exp_t;

    logic        clk;
    logic        resetn      [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [23:0] req_addr    [2];
    logic [31:0] rdata       [2];
    logic        rdata_valid [2];
    logic        busy        [2];
    logic        csb         [2];
    logic        sck         [2];
    logic        mosi        [2];
    logic        miso        [2];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0]  pre [logic [23:0]];
    logic [23:0] dir [6];
    logic [23:0] rnd [NRND];
    int          gaps[NRND];

    exp_t sb0[$];
    exp_t sb1[$];

    // Request-side model of the reader: open burst and expected next address
    logic        hb        [2];
    logic [23:0] na        [2];
    int          exp_cmds  [2];
    logic [23:0] exp_caddr [2];

    // Responder state
    logic        rst_q     [2];
    logic        prev_sck  [2];
    logic        prev_csb  [2];
    int          bcnt      [2];
    int          high_cnt  [2];
    logic [31:0] shreg     [2];
    logic [23:0] ptr       [2];
    int          cmds      [2];
    logic [23:0] last_caddr[2];
    logic [31:0] last_rdata[2];

    spi_flash_reader #(.CLK_DIV(1), .CSB_IDLE(CSB_MIN)) u_dut_d1 (
        .clk(clk), .resetn(resetn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .rdata(rdata[0]), .rdata_valid(rdata_valid[0]), .busy(busy[0]),
        .flash_csb(csb[0]), .flash_clk(sck[0]), .flash_io0(mosi[0]), .flash_io1(miso[0])
    );

    spi_flash_reader #(.CLK_DIV(3), .CSB_IDLE(CSB_MIN)) u_dut_d3 (
        .clk(clk), .resetn(resetn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .rdata(rdata[1]), .rdata_valid(rdata_valid[1]), .busy(busy[1]),
        .flash_csb(csb[1]), .flash_clk(sck[1]), .flash_io0(mosi[1]), .flash_io1(miso[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) rst_q[g] <= resetn[g];
    end

    function automatic int div_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (pre.exists(a)) return pre[a];
        return 8'((a * 24'd131) ^ (a >> 11) ^ 24'h5A);
    endfunction

    function automatic logic [31:0] ref_word(input logic [23:0] w);
        return {mem_byte(w + 24'd3), mem_byte(w + 24'd2), mem_byte(w + 24'd1), mem_byte(w)};
    endfunction

    function automatic int sb_size(input int g);
        return (g == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s lane%0d: got %h, expected %h (cycle %0d)", name, g, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input int g);
        compared++;
        mismatched++;
        $display("FAIL %s lane%0d (cycle %0d)", name, g, cyc);
    endtask

    // Present one request and hold it until the reader takes it; called at a negedge
    task automatic issue(input int g, input logic [23:0] a, input bit expect_rsp);
        logic [23:0] w;
        exp_t        e;
        int          waited;
        w            = a & 24'hFFFFFC;
        req_addr[g]  = a;
        req_valid[g] = 1'b1;
        waited       = 0;
        while (1) begin
            if (req_ready[g] && (!hb[g] || w == na[g])) break;
            if (req_ready[g] && hb[g]) hb[g] = 1'b0;
            @(negedge clk);
            waited++;
            if (waited > 3000) begin
                fail("accept_timeout", g);
                req_valid[g] = 1'b0;
                return;
            end
        end
        if (!hb[g]) begin
            e.lat = 1 + 128 * div_of(g);
            if (expect_rsp) begin
                exp_cmds[g]++;
                exp_caddr[g] = w;
            end
        end else begin
            e.lat = 1 + 64 * div_of(g);
        end
        e.acc      = cyc + 1;
        e.data     = ref_word(w);
        e.cmds     = exp_cmds[g];
        e.cmd_addr = exp_caddr[g];
        hb[g]      = 1'b1;
        na[g]      = w + 24'd4;
        if (expect_rsp) begin
            if (g == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(negedge clk);
        req_valid[g] = 1'b0;
    endtask

    task automatic wait_drain(input int g);
        int n = 0;
        while (sb_size(g) != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sb_size(g) != 0) fail("drain_timeout", g);
    endtask

    task automatic run_lane(input int g);
        repeat (3) @(negedge clk);
        chk("rst_csb", g, 32'(csb[g]), 32'd1);
        chk("rst_sck", g, 32'(sck[g]), 32'd0);
        chk("rst_io0", g, 32'(mosi[g]), 32'd0);
        chk("rst_rdata", g, rdata[g], 32'd0);
        chk("rst_valid", g, 32'(rdata_valid[g]), 32'd0);
        chk("rst_busy", g, 32'(busy[g]), 32'd0);
        resetn[g] = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", g, 32'(req_ready[g]), 32'd1);
        chk("busy_after_reset", g, 32'(busy[g]), 32'd0);

        for (int i = 0; i < 6; i++) issue(g, dir[i], 1'b1);
        wait_drain(g);

        // Abort a fresh transaction part-way through its address phase
        issue(g, 24'h000040, 1'b0);
        repeat (40 * div_of(g)) @(negedge clk);
        resetn[g] = 1'b0;
        @(negedge clk);
        chk("abort_csb", g, 32'(csb[g]), 32'd1);
        chk("abort_sck", g, 32'(sck[g]), 32'd0);
        chk("abort_busy", g, 32'(busy[g]), 32'd0);
        chk("abort_valid", g, 32'(rdata_valid[g]), 32'd0);
        resetn[g] = 1'b1;
        hb[g]     = 1'b0;
        repeat (140 * div_of(g)) @(negedge clk);

        issue(g, 24'h000200, 1'b1);
        for (int i = 0; i < NRND; i++) begin
            repeat (gaps[i]) @(negedge clk);
            issue(g, rnd[i], 1'b1);
        end
        wait_drain(g);
    endtask

    // SPI flash responder: samples MOSI on SCK rise, shifts MISO out on SCK fall
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_q[g]) begin
                bcnt[g]     = 0;
                high_cnt[g] = 100;
                prev_sck[g] = 1'b0;
                prev_csb[g] = 1'b1;
            end else begin
                if (csb[g]) begin
                    bcnt[g] = 0;
                    high_cnt[g]++;
                end else begin
                    if (prev_csb[g]) begin
                        chk("csb_idle_min", g, 32'(high_cnt[g] >= CSB_MIN), 32'd1);
                        high_cnt[g] = 0;
                    end
                    if (sck[g] && !prev_sck[g]) begin
                        if (bcnt[g] < 32) begin
                            shreg[g] = {shreg[g][30:0], mosi[g]};
                            if (bcnt[g] == 31) begin
                                cmds[g]++;
                                chk("cmd_byte", g, 32'(shreg[g][31:24]), 32'h03);
                                last_caddr[g] = shreg[g][23:0];
                                ptr[g]        = shreg[g][23:0];
                            end
                        end
                        bcnt[g]++;
                    end else if (!sck[g] && prev_sck[g] && bcnt[g] >= 32) begin
                        int j;
                        logic [7:0] b;
                        j       = bcnt[g] - 32;
                        b       = mem_byte(ptr[g] + 24'(j / 8));
                        miso[g] = b[7 - (j % 8)];
                    end
                end
                prev_csb[g] = csb[g];
                prev_sck[g] = sck[g];
            end
        end
    end

    // Monitor: pop the scoreboard on each rdata_valid pulse
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_q[g]) begin
                last_rdata[g] = 32'h0;
            end else if (rdata_valid[g]) begin
                if (sb_size(g) == 0) begin
                    fail("stray_rdata_valid", g);
                end else begin
                    exp_t e;
                    if (g == 0) e = sb0.pop_front();
                    else        e = sb1.pop_front();
                    chk("rdata", g, rdata[g], e.data);
                    chk("latency", g, 32'(cyc - e.acc), 32'(e.lat));
                    chk("cmd_count", g, 32'(cmds[g]), 32'(e.cmds));
                    chk("cmd_addr", g, 32'(last_caddr[g]), 32'(e.cmd_addr));
                    chk("hold_ready", g, 32'(req_ready[g]), 32'd1);
                    chk("hold_csb", g, 32'(csb[g]), 32'd0);
                end
                last_rdata[g] = rdata[g];
            end else begin
                chk("rdata_hold", g, rdata[g], last_rdata[g]);
            end
        end
    end

    initial begin
        logic [23:0] prev;
        for (int g = 0; g < 2; g++) begin
            resetn[g]     = 1'b0;
            req_valid[g]  = 1'b0;
            req_addr[g]   = 24'h0;
            miso[g]       = 1'b0;
            hb[g]         = 1'b0;
            na[g]         = 24'h0;
            exp_cmds[g]   = 0;
            exp_caddr[g]  = 24'h0;
            cmds[g]       = 0;
            last_caddr[g] = 24'h0;
            shreg[g]      = 32'h0;
            ptr[g]        = 24'h0;
            last_rdata[g] = 32'h0;
        end
        pre[24'h000000] = 8'h6F; pre[24'h000001] = 8'h00;
        pre[24'h000002] = 8'h40; pre[24'h000003] = 8'h0B;
        pre[24'h000004] = 8'h11; pre[24'h000005] = 8'h22;
        pre[24'h000006] = 8'h33; pre[24'h000007] = 8'h44;
        pre[24'hFFFFFC] = 8'hA1; pre[24'hFFFFFD] = 8'hB2;
        pre[24'hFFFFFE] = 8'hC3; pre[24'hFFFFFF] = 8'hD4;
        dir[0] = 24'h000000;
        dir[1] = 24'h000004;
        dir[2] = 24'h000100;
        dir[3] = 24'h000007;
        dir[4] = 24'hFFFFFC;
        dir[5] = 24'h000000;
        prev = 24'h000200;
        for (int i = 0; i < NRND; i++) begin
            if ($urandom_range(0, 1) == 1) rnd[i] = prev + 24'd4;
            else                           rnd[i] = 24'($urandom);
            prev    = rnd[i] & 24'hFFFFFC;
            gaps[i] = $urandom_range(0, 3);
        end

        fork
            run_lane(0);
            run_lane(1);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #600000;
        mismatched++;
        $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

endmodule
